mem_arbiter: RTL and testbench

Arbitrates the single main-memory port between instruction-cache refills and data-cache refills/writebacks. Transfers are block bursts of BLOCK_WORDS words, word-addressed on a 30-bit bus. The block sits between the instruction fetch stage's cache miss path, the data cache, and the external memory model. Grant is round-robin, and a burst in flight is never preempted.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed main-memory port between instruction
// cache refills and data cache refills/writebacks. Grants are round-robin on a
// tie, whole BLOCK_WORDS bursts are never preempted, and each word advances on mem_ack.
//
// Ports:
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   ic_req, ic_addr             instruction refill request and block address
//   ic_fill_valid/idx/data      registered refill word for the instruction cache
//   ic_done                     one-cycle pulse at the end of an instruction burst
//   dc_req, dc_we, dc_addr      data burst request, direction (1 = writeback), block address
//   dc_wdata, dc_word_idx       writeback word, supplied combinationally for dc_word_idx
//   dc_fill_valid/data          registered refill word for the data cache
//   dc_done                     one-cycle pulse at the end of a data burst
//   mem_req/we/addr/wdata       memory access, driven only during a burst
//   mem_rdata, mem_ack          memory read data and per-word completion

module mem_arbiter #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_fill_valid,
  output logic [IDX_W-1:0]  ic_fill_idx,
  output logic [DATA_W-1:0] ic_fill_data,
  output logic              ic_done,

  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [IDX_W-1:0]  dc_word_idx,
  output logic              dc_fill_valid,
  output logic [DATA_W-1:0] dc_fill_data,
  output logic              dc_done,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BURST = 2'd1,
    D_BURST = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  state_t                   state;
  logic [IDX_W-1:0]         cnt;
  logic [ADDR_W-IDX_W-1:0]  base;
  logic                     we_lat;
  // Side that owned the most recent burst: 0 = instruction, 1 = data.
  logic                     last;

  logic in_burst;
  logic grant_i;
  logic grant_d;

  assign in_burst = (state == I_BURST) || (state == D_BURST);

  // A lone requester always wins; on a tie the side that did not go last wins.
  assign grant_i = ic_req && (!dc_req || last);
  assign grant_d = dc_req && (!ic_req || !last);

  // Word offsets inside a block are regenerated from cnt, so the incoming
  // low address bits carry no information.
  logic unused_low_addr;
  assign unused_low_addr = ^{ic_addr[IDX_W-1:0], dc_addr[IDX_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      base          <= '0;
      we_lat        <= 1'b0;
      last          <= 1'b1;
      ic_fill_valid <= 1'b0;
      ic_fill_idx   <= '0;
      ic_fill_data  <= '0;
      dc_fill_valid <= 1'b0;
      dc_fill_data  <= '0;
    end else begin
      // Fill strobes are single-cycle; data and index hold between strobes.
      ic_fill_valid <= 1'b0;
      dc_fill_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_i) begin
            state  <= I_BURST;
            base   <= ic_addr[ADDR_W-1:IDX_W];
            we_lat <= 1'b0;
            cnt    <= '0;
            last   <= 1'b0;
          end else if (grant_d) begin
            state  <= D_BURST;
            base   <= dc_addr[ADDR_W-1:IDX_W];
            we_lat <= dc_we;
            cnt    <= '0;
            last   <= 1'b1;
          end
        end

        I_BURST, D_BURST: begin
          if (mem_ack) begin
            if (!we_lat) begin
              if (state == I_BURST) begin
                ic_fill_valid <= 1'b1;
                ic_fill_idx   <= cnt;
                ic_fill_data  <= mem_rdata;
              end else begin
                dc_fill_valid <= 1'b1;
                dc_fill_data  <= mem_rdata;
              end
            end
            // cnt wraps inside its own width, so the address never carries
            // into base and stays within the block.
            cnt <= cnt + IDX_W'(1);
            if (cnt == LAST_IDX) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory side is decoded from registered state only; write data is the
  // one combinational path, straight from the data cache.
  assign mem_req     = in_burst;
  assign mem_we      = in_burst && we_lat;
  assign mem_addr    = in_burst ? {base, cnt} : '0;
  assign mem_wdata   = in_burst ? dc_wdata : '0;
  assign dc_word_idx = (state == D_BURST) ? cnt : '0;

  assign ic_done = (state == DONE) && !last;
  assign dc_done = (state == DONE) && last;

  a_fill_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ic_fill_valid && dc_fill_valid));

  a_done_quiet: assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |-> !mem_req);

  a_done_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ic_done && dc_done));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [29:0] ic_addr;
  logic        ic_fill_valid;
  logic [1:0]  ic_fill_idx;
  logic [31:0] ic_fill_data;
  logic        ic_done;
  logic        dc_req;
  logic        dc_we;
  logic [29:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [1:0]  dc_word_idx;
  logic        dc_fill_valid;
  logic [31:0] dc_fill_data;
  logic        dc_done;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_mode;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_fill_valid(ic_fill_valid), .ic_fill_idx(ic_fill_idx),
    .ic_fill_data(ic_fill_data), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_word_idx(dc_word_idx), .dc_fill_valid(dc_fill_valid),
    .dc_fill_data(dc_fill_data), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory returns its own address as data; the data cache supplies 0xA0+idx.
  always_comb mem_rdata = 32'(mem_addr);
  always_comb dc_wdata  = wb_mode ? (32'hA0 + 32'(dc_word_idx)) : 32'h0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task tick;
    @(posedge clk);
    #2;
  endtask

  task test_reset;
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0; mem_ack = 1'b0; wb_mode = 1'b0;
    tick; tick;
    checks++;
    if ({mem_req, mem_we, ic_fill_valid, dc_fill_valid, ic_done, dc_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {mem_req, mem_we, ic_fill_valid, dc_fill_valid, ic_done, dc_done});
    end
    checks++;
    if (mem_addr !== 30'h0 || dc_word_idx !== 2'd0 || ic_fill_data !== 32'h0 || dc_fill_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h idx=%h icd=%h dcd=%h want all 0",
               mem_addr, dc_word_idx, ic_fill_data, dc_fill_data);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req got mem_req=%b want 0", mem_req);
    end
  endtask

  task test_single_i;
    ic_addr = 30'h31; ic_req = 1'b1; mem_ack = 1'b1;
    tick;
    ic_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 30'(32'h30 + k)) begin
        errors++;
        $display("FAIL single_i_addr%0d got req=%b we=%b addr=%h want 1 0 %h",
                 k, mem_req, mem_we, mem_addr, 32'h30 + k);
      end
      checks++;
      if (k == 0) begin
        if (ic_fill_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_i_fill0 got valid=%b want 0", ic_fill_valid);
        end
      end else if (ic_fill_valid !== 1'b1 || ic_fill_idx !== 2'(k - 1) || ic_fill_data !== 32'(32'h30 + k - 1)) begin
        errors++;
        $display("FAIL single_i_fill%0d got v=%b idx=%0d d=%h want 1 %0d %h",
                 k, ic_fill_valid, ic_fill_idx, ic_fill_data, k - 1, 32'h30 + k - 1);
      end
      checks++;
      if (ic_done !== 1'b0 || dc_fill_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_i_early got ic_done=%b dc_fv=%b want 0 0", ic_done, dc_fill_valid);
      end
      tick;
    end
    checks++;
    if ({mem_req, ic_done, dc_done, ic_fill_valid} !== 4'b0101 || ic_fill_idx !== 2'd3 || ic_fill_data !== 32'h33) begin
      errors++;
      $display("FAIL single_i_done got req=%b icd=%b dcd=%b fv=%b idx=%0d d=%h want 0 1 0 1 3 33",
               mem_req, ic_done, dc_done, ic_fill_valid, ic_fill_idx, ic_fill_data);
    end
    tick;
    checks++;
    if ({mem_req, ic_done, ic_fill_valid} !== 3'b000 || ic_fill_idx !== 2'd3 || ic_fill_data !== 32'h33) begin
      errors++;
      $display("FAIL single_i_hold got req=%b icd=%b fv=%b idx=%0d d=%h want 0 0 0 3 33",
               mem_req, ic_done, ic_fill_valid, ic_fill_idx, ic_fill_data);
    end
  endtask

  task test_tie;
    int n;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ic_addr = 30'h40; dc_addr = 30'h80; dc_we = 1'b0; mem_ack = 1'b1;
    ic_req = 1'b1; dc_req = 1'b1;
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h40) begin
      errors++;
      $display("FAIL tie_first got req=%b addr=%h want 1 40", mem_req, mem_addr);
    end
    ic_req = 1'b0;
    tick; tick; tick; tick;
    checks++;
    if (ic_done !== 1'b1 || dc_done !== 1'b0) begin
      errors++;
      $display("FAIL tie_ic_done got ic_done=%b dc_done=%b want 1 0", ic_done, dc_done);
    end
    tick;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL tie_gap got mem_req=%b want 0", mem_req);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h80 || dc_word_idx !== 2'd0) begin
      errors++;
      $display("FAIL tie_second got req=%b we=%b addr=%h idx=%0d want 1 0 80 0",
               mem_req, mem_we, mem_addr, dc_word_idx);
    end
    ic_req = 1'b1;
    n = 0;
    while (dc_done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (n + 2 != 6) begin
      errors++;
      $display("FAIL tie_done_gap got %0d cycles want 6", n + 2);
    end
    checks++;
    if (dc_fill_valid !== 1'b1 || dc_fill_data !== 32'h83 || ic_fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL tie_dc_fill got dfv=%b d=%h ifv=%b want 1 83 0", dc_fill_valid, dc_fill_data, ic_fill_valid);
    end
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h40) begin
      errors++;
      $display("FAIL tie_third got req=%b addr=%h want 1 40", mem_req, mem_addr);
    end
    ic_req = 1'b0; dc_req = 1'b0;
    tick; tick; tick; tick;
    checks++;
    if (ic_done !== 1'b1) begin
      errors++;
      $display("FAIL tie_third_done got ic_done=%b want 1", ic_done);
    end
    tick;
  endtask

  task test_writeback;
    int w;
    int done_cnt;
    int fv_cnt;
    wb_mode = 1'b1; dc_we = 1'b1; dc_addr = 30'h100; dc_req = 1'b1; mem_ack = 1'b0;
    tick;
    dc_req = 1'b0;
    w = 0; done_cnt = 0; fv_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ack = (c % 3 == 2);
      if (w < 4) begin
        checks++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 30'(32'h100 + w) ||
            mem_wdata !== 32'(32'hA0 + w) || dc_word_idx !== 2'(w)) begin
          errors++;
          $display("FAIL wb_word%0d c%0d got req=%b we=%b addr=%h wd=%h idx=%0d want 1 1 %h %h %0d",
                   w, c, mem_req, mem_we, mem_addr, mem_wdata, dc_word_idx, 32'h100 + w, 32'hA0 + w, w);
        end
      end
      if (dc_fill_valid === 1'b1) fv_cnt++;
      if (dc_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (mem_req !== 1'b0) begin
          errors++;
          $display("FAIL wb_done_req got mem_req=%b want 0", mem_req);
        end
      end
      if (mem_ack && w < 4) w++;
      tick;
    end
    mem_ack = 1'b0;
    checks++;
    if (done_cnt != 1 || fv_cnt != 0) begin
      errors++;
      $display("FAIL wb_summary got done=%0d fill_valid=%0d want 1 0", done_cnt, fv_cnt);
    end
    wb_mode = 1'b0; dc_we = 1'b0;
  endtask

  task test_dc_mid_i;
    ic_addr = 30'h2E; ic_req = 1'b1; mem_ack = 1'b1;
    tick;
    ic_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 30'h204; ic_addr = 30'h999;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 30'(32'h2C + k)) begin
        errors++;
        $display("FAIL mid_i_addr%0d got req=%b addr=%h want 1 %h", k, mem_req, mem_addr, 32'h2C + k);
      end
      tick;
    end
    checks++;
    if (ic_done !== 1'b1 || dc_done !== 1'b0 || ic_fill_data !== 32'h2F) begin
      errors++;
      $display("FAIL mid_i_done got icd=%b dcd=%b d=%h want 1 0 2f", ic_done, dc_done, ic_fill_data);
    end
    tick;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_i_gap got mem_req=%b want 0", mem_req);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h204 || dc_word_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_i_dgrant got req=%b addr=%h idx=%0d want 1 204 0", mem_req, mem_addr, dc_word_idx);
    end
    dc_req = 1'b0;
    tick; tick; tick; tick;
    checks++;
    if (dc_done !== 1'b1 || dc_fill_valid !== 1'b1 || dc_fill_data !== 32'h207 || ic_fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_i_ddone got dcd=%b dfv=%b d=%h ifv=%b want 1 1 207 0",
               dc_done, dc_fill_valid, dc_fill_data, ic_fill_valid);
    end
    tick;
  endtask

  task test_reset_mid;
    ic_addr = 30'h50; ic_req = 1'b1; mem_ack = 1'b1;
    tick; tick; tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h52) begin
      errors++;
      $display("FAIL rstmid_word2 got req=%b addr=%h want 1 52", mem_req, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 30'h0 || ic_done !== 1'b0 || ic_fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop got req=%b addr=%h icd=%b fv=%b want 0 0 0 0",
               mem_req, mem_addr, ic_done, ic_fill_valid);
    end
    tick;
    checks++;
    if (ic_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_hold got icd=%b req=%b want 0 0", ic_done, mem_req);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h50) begin
      errors++;
      $display("FAIL rstmid_restart got req=%b addr=%h want 1 50", mem_req, mem_addr);
    end
    ic_req = 1'b0;
    tick; tick; tick; tick;
    checks++;
    if (ic_done !== 1'b1 || ic_fill_data !== 32'h53) begin
      errors++;
      $display("FAIL rstmid_done got icd=%b d=%h want 1 53", ic_done, ic_fill_data);
    end
    tick;
  endtask

  task test_drop_mid;
    ic_addr = 30'h60; ic_req = 1'b1; mem_ack = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) ic_req = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 30'(32'h60 + k)) begin
        errors++;
        $display("FAIL drop_addr%0d got req=%b addr=%h want 1 %h", k, mem_req, mem_addr, 32'h60 + k);
      end
      tick;
    end
    checks++;
    if (ic_done !== 1'b1 || ic_fill_idx !== 2'd3 || ic_fill_data !== 32'h63) begin
      errors++;
      $display("FAIL drop_done got icd=%b idx=%0d d=%h want 1 3 63", ic_done, ic_fill_idx, ic_fill_data);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (mem_req !== 1'b0 || ic_done !== 1'b0) begin
        errors++;
        $display("FAIL drop_idle%0d got req=%b icd=%b want 0 0", k, mem_req, ic_done);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_i;
    test_tie;
    test_writeback;
    test_dc_mid_i;
    test_reset_mid;
    test_drop_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
